mealy_decoder: RTL and testbench

//  Receive-side inverse of the team's 4-state Mealy serial coder. Takes the coded bit

---
 rtl/mealy_decoder_pkg.sv | 28 ++
 rtl/mealy_decoder_if.sv | 23 ++
 rtl/mealy_dec_core.sv | 46 ++++
 rtl/mealy_decoder.sv | 85 ++++++++
 tb/tb_mealy_decoder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mealy_decoder_pkg.sv
// rtl/mealy_decoder_pkg.sv - state encoding and decode function shared with the Mealy serial coder
package mealy_code_pkg;

  typedef enum logic [1:0] {
    D0 = 2'b00,
    D1 = 2'b01,
    D2 = 2'b10,
    D3 = 2'b11
  } state_t;

  typedef struct packed {
    state_t next_state;
    logic   dbit;
  } dec_t;

  // Inverse of the coder: every (state, din) pair is legal, so no error state exists.
  function automatic dec_t mealy_decode(input state_t state, input logic din);
    dec_t r;
    case (state)
      D0:      begin r.next_state = din ? D0 : D1; r.dbit =  din; end
      D1:      begin r.next_state = din ? D2 : D3; r.dbit = ~din; end
      D2:      begin r.next_state = din ? D0 : D1; r.dbit = ~din; end
      default: begin r.next_state = din ? D2 : D3; r.dbit =  din; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mealy_decoder_if.sv
// rtl/mealy_decoder_if.sv - coded-bit input and decoded bit/word outputs of the Mealy decoder
interface mealy_decoder_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             din;
  logic             din_vld;
  logic             bit_out;
  logic             bit_vld;
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             par_err;

  modport master (
    output clr, din, din_vld,
    input  bit_out, bit_vld, word_out, word_vld, par_err
  );

  modport slave (
    input  clr, din, din_vld,
    output bit_out, bit_vld, word_out, word_vld, par_err
  );
endinterface

// File: rtl/mealy_dec_core.sv
// rtl/mealy_dec_core.sv - 4-state decoder FSM tracking the coder, with registered bit_out/bit_vld
module mealy_dec_core
  import mealy_code_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  input  logic din_vld,
  output logic accept,
  output logic dec_bit,
  output logic bit_out,
  output logic bit_vld
);

  state_t state;
  state_t state_nxt;
  dec_t   dec;

  always_comb begin
    dec       = mealy_decode(state, din);
    accept    = din_vld & ~clr;
    dec_bit   = dec.dbit;
    state_nxt = state;
    if (clr) begin
      state_nxt = D0;
    end else if (din_vld) begin
      state_nxt = dec.next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= D0;
      bit_out <= 1'b0;
      bit_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_vld <= accept;
      if (accept) begin
        bit_out <= dec.dbit;
      end
    end
  end

endmodule

// File: rtl/mealy_decoder.sv
// rtl/mealy_decoder.sv - Mealy serial decoder with LSB-first word packing
// Optional PARITY_CHK_EN: frames carry a trailing even-parity bit checked into par_err.
module mealy_decoder
  import mealy_code_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  mealy_decoder_if.slave  bus
);

`ifdef PARITY_CHK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME);

  logic             accept;
  logic             dec_bit;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;

  mealy_dec_core u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.clr),
    .din     (bus.din),
    .din_vld (bus.din_vld),
    .accept  (accept),
    .dec_bit (dec_bit),
    .bit_out (bus.bit_out),
    .bit_vld (bus.bit_vld)
  );

  assign last = (cnt == CNT_W'(FRAME - 1));

`ifdef PARITY_CHK_EN
  logic par_q;
  assign bus.par_err = par_q;
`else
  assign bus.par_err = 1'b0;
`endif

  // Bits enter at the MSB and shift down, so after WIDTH bits the first one sits at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      shreg        <= '0;
      bus.word_out <= '0;
      bus.word_vld <= 1'b0;
`ifdef PARITY_CHK_EN
      par_q        <= 1'b0;
`endif
    end else begin
      bus.word_vld <= 1'b0;
`ifdef PARITY_CHK_EN
      par_q        <= 1'b0;
`endif
      if (bus.clr) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= last ? '0 : cnt + 1'b1;
`ifdef PARITY_CHK_EN
        if (last) begin
          bus.word_out <= shreg;
          bus.word_vld <= 1'b1;
          par_q        <= (^shreg) ^ dec_bit;
        end else begin
          shreg <= {dec_bit, shreg[WIDTH-1:1]};
        end
`else
        shreg <= {dec_bit, shreg[WIDTH-1:1]};
        if (last) begin
          bus.word_out <= {dec_bit, shreg[WIDTH-1:1]};
          bus.word_vld <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_mealy_decoder.sv
// tb/tb_mealy_decoder.sv - self-checking bench: vector table, directed corners, random round-trip vs coder model
module tb_mealy_decoder;

  localparam int WIDTH = 8;
`ifdef PARITY_CHK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = WIDTH + (PAR ? 1 : 0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mealy_decoder_if #(.WIDTH(WIDTH)) bus ();
  mealy_decoder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;

  // Forward coder, indexed [state][x]: the reference decodes by finding the x that produced din.
  int ENC_NEXT [4][2];
  bit ENC_Y    [4][2];

  int         ms;
  bit         q[$];
  logic       e_bo, e_bv, e_wv, e_pe;
  logic [7:0] e_wo;

  typedef struct {
    bit         rst_first;
    logic       din;
    logic       exp_bit;
    logic       exp_wvld;
    logic [7:0] exp_word;
    logic [1:0] exp_state;
  } vec_t;
  vec_t vt [16];

  logic [7:0] stream;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = 0; q.delete();
    e_bo = 0; e_bv = 0; e_wv = 0; e_pe = 0; e_wo = '0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic c);
    bit x;
    logic [7:0] w;
    bit p;
    e_bv = 0; e_wv = 0; e_pe = 0;
    if (c) begin
      ms = 0; q.delete();
    end else if (v) begin
      x = (ENC_Y[ms][1] == d);
      ms = ENC_NEXT[ms][x];
      e_bo = x; e_bv = 1;
      q.push_back(x);
      if (q.size() == FRAME) begin
        w = '0; p = 0;
        for (int i = 0; i < WIDTH; i++) w[i] = q[i];
        for (int i = 0; i < FRAME; i++) p ^= q[i];
        e_wo = w; e_wv = 1; e_pe = PAR ? p : 1'b0;
        q.delete();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bit_vld"},  bus.bit_vld,  e_bv);
    check({tag, ".bit_out"},  bus.bit_out,  e_bo);
    check({tag, ".word_vld"}, bus.word_vld, e_wv);
    check({tag, ".word_out"}, bus.word_out, e_wo);
    check({tag, ".par_err"},  bus.par_err,  e_pe);
    check({tag, ".state"},    dut.u_core.state, ms);
  endtask

  task automatic stepm(input string tag, input logic v, input logic d, input logic c);
    bus.din_vld = v; bus.din = d; bus.clr = c;
    model_step(v, d, c);
    @(posedge clk); #1;
    if (bus.word_vld === 1'b1) wv_cnt++;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.din_vld = 0; bus.din = 0; bus.clr = 0;
    @(posedge clk); #1;
    model_reset();
    check_all("reset");
    rst = 1'b0;
    wv_cnt = 0;
  endtask

  task automatic send_stream(input string tag, input int gap);
    for (int i = 0; i < 8; i++) begin
      stepm(tag, 1'b1, stream[i], 1'b0);
      if (i == 3) for (int g = 0; g < gap; g++) stepm({tag, ".gap"}, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    ENC_NEXT = '{'{1, 0}, '{2, 3}, '{0, 1}, '{3, 2}};
    ENC_Y    = '{'{0, 1}, '{1, 0}, '{1, 0}, '{0, 1}};
    stream   = 8'hD9;  // coded 1,0,0,1,1,0,1,1 in bit order 0..7
    bus.clr = 0; bus.din = 0; bus.din_vld = 0;
    model_reset();

    // Coded 1,0,0,1,1,0,1,1 then 1 x8, each from reset.
    vt[0]  = '{1, 1, 1, 0, 8'h00, 2'd0};
    vt[1]  = '{0, 0, 0, 0, 8'h00, 2'd1};
    vt[2]  = '{0, 0, 1, 0, 8'h00, 2'd3};
    vt[3]  = '{0, 1, 1, 0, 8'h00, 2'd2};
    vt[4]  = '{0, 1, 0, 0, 8'h00, 2'd0};
    vt[5]  = '{0, 0, 0, 0, 8'h00, 2'd1};
    vt[6]  = '{0, 1, 0, 0, 8'h00, 2'd2};
    vt[7]  = '{0, 1, 0, 1, 8'h0D, 2'd0};
    for (int i = 8; i < 16; i++) vt[i] = '{(i == 8), 1, 1, (i == 15), 8'hFF, 2'd0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (vt[i].rst_first) do_reset();
      stepm("tbl", 1'b1, vt[i].din, 1'b0);
      check("tbl.bit_out_const", bus.bit_out, vt[i].exp_bit);
      check("tbl.word_vld_const", bus.word_vld, vt[i].exp_wvld & ~PAR);
      check("tbl.state_const", dut.u_core.state, vt[i].exp_state);
      if (vt[i].exp_wvld && !PAR) check("tbl.word_const", bus.word_out, vt[i].exp_word);
    end

    // Idle gap inside a word.
    do_reset();
    send_stream("gap", 3);
    if (PAR) stepm("gap.par", 1'b1, 1'b1, 1'b0);
    check("gap.word_count", wv_cnt, 1);
    check("gap.word", bus.word_out, 8'h0D);

    // Partial word abandoned by clr.
    do_reset();
    stepm("clr.pre", 1'b1, 1'b1, 1'b0);
    stepm("clr.pre", 1'b1, 1'b1, 1'b0);
    stepm("clr.pre", 1'b1, 1'b0, 1'b0);
    stepm("clr.pre", 1'b1, 1'b1, 1'b0);
    stepm("clr.pre", 1'b1, 1'b0, 1'b0);
    stepm("clr", 1'b1, 1'b1, 1'b1);
    send_stream("clr.post", 0);
    if (PAR) stepm("clr.par", 1'b1, 1'b1, 1'b0);
    check("clr.word_count", wv_cnt, 1);
    check("clr.word", bus.word_out, 8'h0D);

`ifdef PARITY_CHK_EN
    do_reset();
    send_stream("par.ok", 0);
    stepm("par.ok", 1'b1, 1'b1, 1'b0);
    check("par.ok.err", bus.par_err, 1'b0);
    check("par.ok.word", bus.word_out, 8'h0D);
    do_reset();
    send_stream("par.bad", 0);
    stepm("par.bad", 1'b1, 1'b0, 1'b0);
    check("par.bad.err", bus.par_err, 1'b1);
    check("par.bad.vld", bus.word_vld, 1'b1);
`endif

    // Asynchronous reset mid-frame.
    do_reset();
    stepm("arst.pre", 1'b1, 1'b0, 1'b0);
    stepm("arst.pre", 1'b1, 1'b0, 1'b0);
    stepm("arst.pre", 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("arst.bit_vld", bus.bit_vld, 1'b0);
    check("arst.bit_out", bus.bit_out, 1'b0);
    check("arst.state", dut.u_core.state, 2'd0);
    @(negedge clk); rst = 1'b0;
    wv_cnt = 0;
    send_stream("arst.post", 0);
    if (PAR) stepm("arst.par", 1'b1, 1'b1, 1'b0);
    check("arst.word_count", wv_cnt, 1);

    // Random round trip: encode random data with the coder model, expect it back.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit x;
      logic v, c;
      x = 1'($urandom % 2);
      v = ($urandom % 4) != 0;
      c = ($urandom % 25) == 0;
      stepm("rnd", v, ENC_Y[ms][x], c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
